// File: rtl/alu_issue_if.sv
// Issue-stage bus: instruction handshake, ALU operand/result path, writeback and debug port.
// The issue stage connects as slave; the instruction source / ALU side connects as master.
interface alu_issue_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    modport master (
        output instr, instr_valid, alu_result, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, illegal, dbg_data
    );

    modport slave (
        input  instr, instr_valid, alu_result, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_op, wb_valid, wb_rd, wb_data, illegal, dbg_data
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM issue stage for the registered ALU: decode, register file read with
// EX forwarding, one-cycle stall on an ISSUE-stage dependency, and writeback of the ALU result.
module alu_issue #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic        clk,
    input logic        rst_n,
    alu_issue_if.slave bus
);
    localparam logic [5:0] OP_ADD   = 6'd0;
    localparam logic [5:0] OP_SUB   = 6'd1;
    localparam logic [5:0] OP_SLL   = 6'd2;
    localparam logic [5:0] OP_SLT   = 6'd3;
    localparam logic [5:0] OP_SLTU  = 6'd4;
    localparam logic [5:0] OP_XOR   = 6'd5;
    localparam logic [5:0] OP_SRL   = 6'd6;
    localparam logic [5:0] OP_SRA   = 6'd7;
    localparam logic [5:0] OP_OR    = 6'd8;
    localparam logic [5:0] OP_AND   = 6'd9;
    localparam logic [5:0] OP_ADDI  = 6'd16;
    localparam logic [5:0] OP_SLTI  = 6'd17;
    localparam logic [5:0] OP_SLTIU = 6'd18;
    localparam logic [5:0] OP_XORI  = 6'd19;
    localparam logic [5:0] OP_ORI   = 6'd20;
    localparam logic [5:0] OP_ANDI  = 6'd21;
    localparam logic [5:0] OP_SLLI  = 6'd22;
    localparam logic [5:0] OP_SRLI  = 6'd23;
    localparam logic [5:0] OP_SRAI  = 6'd24;

    logic [XLEN-1:0] rf [NREGS];

    logic            iss_v, ex_v, illegal_q;
    logic [4:0]      iss_rd, ex_rd;
    logic [XLEN-1:0] alu_a_q, alu_b_q;
    logic [5:0]      alu_op_q;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rd, rs1, rs2;
    logic            is_op, is_opimm, legal, use_imm, shamt_imm;
    logic [5:0]      dec_op;
    logic            hazard, ready, accept;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_b, op_b;

    assign opcode   = bus.instr[6:0];
    assign rd       = bus.instr[11:7];
    assign funct3   = bus.instr[14:12];
    assign rs1      = bus.instr[19:15];
    assign rs2      = bus.instr[24:20];
    assign funct7   = bus.instr[31:25];
    assign is_op    = (opcode == 7'b0110011);
    assign is_opimm = (opcode == 7'b0010011);

    always_comb begin
        legal     = 1'b0;
        dec_op    = OP_ADD;
        use_imm   = 1'b0;
        shamt_imm = 1'b0;
        if (is_op) begin
            legal = 1'b1;
            case ({funct7, funct3})
                10'b0000000_000: dec_op = OP_ADD;
                10'b0000000_001: dec_op = OP_SLL;
                10'b0000000_010: dec_op = OP_SLT;
                10'b0000000_011: dec_op = OP_SLTU;
                10'b0000000_100: dec_op = OP_XOR;
                10'b0000000_101: dec_op = OP_SRL;
                10'b0000000_110: dec_op = OP_OR;
                10'b0000000_111: dec_op = OP_AND;
                10'b0100000_000: dec_op = OP_SUB;
                10'b0100000_101: dec_op = OP_SRA;
                default:         legal  = 1'b0;
            endcase
        end else if (is_opimm) begin
            legal   = 1'b1;
            use_imm = 1'b1;
            case (funct3)
                3'b000: dec_op = OP_ADDI;
                3'b010: dec_op = OP_SLTI;
                3'b011: dec_op = OP_SLTIU;
                3'b100: dec_op = OP_XORI;
                3'b110: dec_op = OP_ORI;
                3'b111: dec_op = OP_ANDI;
                3'b001: begin
                    shamt_imm = 1'b1;
                    dec_op    = OP_SLLI;
                    legal     = (funct7 == 7'b0000000);
                end
                default: begin
                    shamt_imm = 1'b1;
                    if (funct7 == 7'b0000000)      dec_op = OP_SRLI;
                    else if (funct7 == 7'b0100000) dec_op = OP_SRAI;
                    else                           legal  = 1'b0;
                end
            endcase
        end
    end

    // Only the ISSUE-stage result is not yet visible; EX results are forwarded from alu_result.
    assign hazard = iss_v && (iss_rd != 5'd0) && (is_op || is_opimm) &&
                    ((rs1 == iss_rd) || (is_op && (rs2 == iss_rd)));
    assign ready  = rst_n && !hazard;
    assign accept = bus.instr_valid && ready;

    assign rs1_val = (rs1 == 5'd0) ? '0 :
                     (ex_v && (ex_rd == rs1)) ? bus.alu_result : rf[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 :
                     (ex_v && (ex_rd == rs2)) ? bus.alu_result : rf[rs2];
    assign imm_b   = shamt_imm ? {27'b0, bus.instr[24:20]} : {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign op_b    = use_imm ? imm_b : rs2_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_v     <= 1'b0;
            ex_v      <= 1'b0;
            illegal_q <= 1'b0;
            iss_rd    <= '0;
            ex_rd     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= OP_ADD;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            iss_v     <= accept && legal;
            illegal_q <= accept && !legal;
            if (accept) iss_rd <= rd;
            if (accept && legal) begin
                alu_a_q  <= rs1_val;
                alu_b_q  <= op_b;
                alu_op_q <= dec_op;
            end
            ex_v  <= iss_v;
            ex_rd <= iss_rd;
            if (ex_v && (ex_rd != 5'd0)) rf[ex_rd] <= bus.alu_result;
        end
    end

    assign bus.instr_ready = ready;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.illegal     = illegal_q;
    assign bus.wb_valid    = ex_v;
    assign bus.wb_rd       = ex_rd;
    assign bus.wb_data     = bus.alu_result;
    assign bus.dbg_data    = (bus.dbg_addr == 5'd0) ? '0 : rf[bus.dbg_addr];
endmodule
